rat_call_stack: RTL

//  Hardware return-address stack for the RAT core: the other end of the PC's FROM_STACK path.
//  - CALL: the control unit pushes the current PC value.
//  - RET/RETI: the control unit pops, and the top of stack drives the PC's FROM_STACK input.
//  - Top of stack is readable in the same cycle, so one edge does POP and the PC load.

---
 rtl/rat_stack_pkg.sv | 16 +
 rtl/rat_stack_ram.sv | 27 ++
 rtl/rat_call_stack.sv | 121 ++++++++++++
 3 files changed

// File: rtl/rat_stack_pkg.sv
// Shared definitions for the RAT return-address stack.
// RAT_ADDR_W matches the PC width; stack_op_t is the {PUSH,POP} decode.
// Imported by rat_stack_ram and rat_call_stack.
package rat_stack_pkg;

  localparam int RAT_ADDR_W = 10;

  // Encoding equals the raw {PUSH,POP} pair so a plain cast decodes it.
  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_REPL = 2'b11
  } stack_op_t;

endpackage

// File: rtl/rat_stack_ram.sv
// Entry storage for the return-address stack: DEPTH x ADDR_W, no reset.
// Ports: clk, we_i/waddr_i/wdata_i (sync write), raddr_i/rdata_o (async read).
// Read is combinational so the top of stack is usable in the same cycle.
module rat_stack_ram #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [ADDR_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [ADDR_W-1:0] rdata_o
);

  logic [ADDR_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rat_call_stack.sv
// Hardware return-address stack for the RAT core (CALL pushes, RET/RETI pops).
// Ports: clk, RST (async active-low), PUSH/POP/PC_IN in; TO_PC (comb top), SP_OUT, EMPTY, FULL out.
// Optional RAT_STACK_ERR_EN adds ERR_CLR in and sticky OVF/UNF out.
module rat_call_stack
  import rat_stack_pkg::*;
#(
  parameter int ADDR_W = RAT_ADDR_W,
  parameter int DEPTH  = 16,
  localparam int SP_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              PUSH,
  input  logic              POP,
  input  logic [ADDR_W-1:0] PC_IN,
  output logic [ADDR_W-1:0] TO_PC,
  output logic [SP_W-1:0]   SP_OUT,
  output logic              EMPTY,
  output logic              FULL
`ifdef RAT_STACK_ERR_EN
  ,
  input  logic              ERR_CLR,
  output logic              OVF,
  output logic              UNF
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(DEPTH);

  stack_op_t         op;
  logic [SP_W-1:0]   sp_q, sp_d, sp_dec;
  logic              we;
  logic [IDX_W-1:0]  waddr;
  logic [ADDR_W-1:0] rdata;

  assign op     = stack_op_t'({PUSH, POP});
  assign sp_dec = sp_q - SP_ONE;
  assign EMPTY  = (sp_q == '0);
  assign FULL   = (sp_q == SP_FULL);
  assign SP_OUT = sp_q;

  // Top entry lives at SP-1; the RAM output is masked to zero when empty.
  assign TO_PC = EMPTY ? '0 : rdata;

  always_comb begin
    sp_d  = sp_q;
    we    = 1'b0;
    waddr = sp_q[IDX_W-1:0];
    case (op)
      OP_PUSH: begin
        if (!FULL) begin
          we   = 1'b1;
          sp_d = sp_q + SP_ONE;
        end
      end
      OP_POP: begin
        if (!EMPTY) begin
          sp_d = sp_dec;
        end
      end
      OP_REPL: begin
        // Overwrite the top in place; on an empty stack this degenerates to a push.
        we = 1'b1;
        if (EMPTY) begin
          sp_d = SP_ONE;
        end else begin
          waddr = sp_dec[IDX_W-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  rat_stack_ram #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (PC_IN),
    .raddr_i (sp_dec[IDX_W-1:0]),
    .rdata_o (rdata)
  );

`ifdef RAT_STACK_ERR_EN
  logic ovf_q, ovf_d, unf_q, unf_d;

  // Clear first, then set, so a fault on the clearing edge is still recorded.
  always_comb begin
    ovf_d = ERR_CLR ? 1'b0 : ovf_q;
    unf_d = ERR_CLR ? 1'b0 : unf_q;
    if (op == OP_PUSH && FULL)  ovf_d = 1'b1;
    if (op == OP_POP  && EMPTY) unf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign OVF = ovf_q;
  assign UNF = unf_q;
`endif

endmodule
